pkt_capture: RTL and testbench

Ingress stage directly upstream of the FIFO-to-Avalon burst writer. It accepts Ethernet frames from the MAC as a 32-bit Avalon-ST sink and writes whole words into the shared data FIFO. At end of frame it issues a one-cycle start pulse to the writer with control, byte range and destination address. It then waits for the writer's done pulse and advances a ring-buffer write pointer in host memory. One packet is in flight at a time.

---
 rtl/pkt_capture_pkg.sv | 40 ++++
 rtl/capture_ring_ptr.sv | 45 ++++
 rtl/pkt_capture.sv | 187 ++++++++++++++++++
 tb/tb_pkt_capture.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_capture_pkg.sv
// Shared types and constants for the pkt_capture ingress block.
// PKT_CAPTURE_TS_EN adds the TRAILER state used for the timestamp word.
package pkt_capture_pkg;

`ifdef PKT_CAPTURE_TS_EN
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_TRAILER = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3
  } state_t;
`endif

  localparam int CTRL_VALID   = 0;
  localparam int CTRL_TRUNC   = 1;
  localparam int CTRL_TSMISS  = 2;
  localparam int CTRL_LEN_LSB = 16;

  localparam int BEAT_BYTES = 4;
  localparam int ADDR_ALIGN = 16;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [2:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {14'd0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] a);
    return (a == 32'hFFFF_FFFF) ? a : (a + 32'd1);
  endfunction

endpackage

// File: rtl/capture_ring_ptr.sv
// Host ring-buffer write pointer: advances by the 16-byte-aligned packet size
// on writer completion and wraps when the next maximum-size packet would not fit.
module capture_ring_ptr
  import pkt_capture_pkg::*;
#(
  parameter int          MAX_PKT_BYTES = 1520,
  parameter logic [31:0] BUF_BASE      = 32'h0000_0000,
  parameter logic [31:0] BUF_SIZE      = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  input  logic [31:0] len,
  output logic [31:0] write_address
);

  logic [32:0] step;
  logic [32:0] next_addr;
  logic [32:0] limit;
  logic [31:0] addr_next;

  // Align-up, advance and wrap decision for the next packet slot
  always_comb begin
    step      = ({1'b0, len} + 33'(ADDR_ALIGN - 1)) & ~33'(ADDR_ALIGN - 1);
    next_addr = {1'b0, write_address} + step;
    limit     = {1'b0, BUF_BASE} + {1'b0, BUF_SIZE};
    if ((next_addr + 33'(MAX_PKT_BYTES)) > limit) begin
      addr_next = BUF_BASE;
    end else begin
      addr_next = next_addr[31:0];
    end
  end

  // Pointer register
  always_ff @(posedge clk) begin
    if (!reset) begin
      write_address <= BUF_BASE;
    end else if (advance) begin
      write_address <= addr_next;
    end else begin
      write_address <= write_address;
    end
  end

endmodule

// File: rtl/pkt_capture.sv
// Avalon-ST frame capture into the shared data FIFO with one-packet-in-flight
// hand-off to the burst writer. Build macro PKT_CAPTURE_TS_EN appends a timestamp word.
module pkt_capture
  import pkt_capture_pkg::*;
#(
  parameter int          MAX_PKT_BYTES = 1520,
  parameter logic [31:0] BUF_BASE      = 32'h0000_0000,
  parameter logic [31:0] BUF_SIZE      = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] st_data,
  input  logic        st_valid,
  input  logic        st_sop,
  input  logic        st_eop,
  input  logic [1:0]  st_empty,
  output logic        st_ready,
  output logic [31:0] fifo_in,
  output logic        wr_to_fifo,
  input  logic        fifo_full,
  output logic        wr_ctrl,
  input  logic        wr_ctrl_rdy,
  output logic [31:0] control,
  output logic [31:0] pkt_begin,
  output logic [31:0] pkt_end,
  output logic [31:0] write_address,
  output logic [31:0] drop_cnt
);

  state_t      state, state_next, close_state;
  logic        wr_to_fifo_next;
  logic [31:0] fifo_in_next, control_next, pkt_end_next, drop_cnt_next;
  logic [2:0]  beat_bytes;
  logic        new_sop, room, keep_word, sop_accept;

  assign pkt_begin = 32'd0;

`ifdef PKT_CAPTURE_TS_EN
  logic [31:0] ts_cnt, ts_latch;
  assign close_state = ST_TRAILER;

  // Free-running cycle counter, sampled when a frame is accepted
  always_ff @(posedge clk) begin
    if (!reset) begin
      ts_cnt   <= 32'd0;
      ts_latch <= 32'd0;
    end else begin
      ts_cnt   <= ts_cnt + 32'd1;
      ts_latch <= sop_accept ? ts_cnt : ts_latch;
    end
  end
`else
  assign close_state = ST_ISSUE;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_next      = state;
    fifo_in_next    = fifo_in;
    wr_to_fifo_next = 1'b0;
    control_next    = control;
    pkt_end_next    = pkt_end;
    drop_cnt_next   = drop_cnt;
    sop_accept      = 1'b0;
    new_sop         = st_valid && st_sop;
    beat_bytes      = st_eop ? (3'(BEAT_BYTES) - {1'b0, st_empty}) : 3'(BEAT_BYTES);
    room            = (pkt_end + 32'(BEAT_BYTES)) <= 32'(MAX_PKT_BYTES);
    // Once truncated, stay truncated so a FIFO that drains later cannot leave a hole
    keep_word       = !fifo_full && room && !control[CTRL_TRUNC];
    case (state)
      ST_IDLE: begin
        if (new_sop && enable) begin
          sop_accept   = 1'b1;
          control_next = 32'd0;
          control_next[CTRL_TSMISS] = 1'b0;
          control_next[CTRL_LEN_LSB +: 16] = {13'd0, beat_bytes};
          if (!fifo_full) begin
            wr_to_fifo_next = 1'b1;
            fifo_in_next    = st_data;
            pkt_end_next    = 32'(BEAT_BYTES);
          end else begin
            pkt_end_next = 32'd0;
            control_next[CTRL_TRUNC] = 1'b1;
          end
          if (st_eop) begin
            control_next[CTRL_VALID] = 1'b1;
            state_next = close_state;
          end else begin
            state_next = ST_CAPTURE;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        if (new_sop) begin
          drop_cnt_next = sat_inc32(drop_cnt);
          control_next[CTRL_TRUNC] = 1'b1;
          control_next[CTRL_VALID] = 1'b1;
          state_next = close_state;
        end else if (st_valid) begin
          control_next[CTRL_LEN_LSB +: 16] = sat_add16(control[CTRL_LEN_LSB +: 16], beat_bytes);
          if (keep_word) begin
            wr_to_fifo_next = 1'b1;
            fifo_in_next    = st_data;
            pkt_end_next    = pkt_end + 32'(BEAT_BYTES);
          end else begin
            control_next[CTRL_TRUNC] = 1'b1;
          end
          if (st_eop) begin
            control_next[CTRL_VALID] = 1'b1;
            state_next = close_state;
          end else begin
            state_next = ST_CAPTURE;
          end
        end else begin
          state_next = ST_CAPTURE;
        end
      end
`ifdef PKT_CAPTURE_TS_EN
      ST_TRAILER: begin
        if (!fifo_full) begin
          wr_to_fifo_next = 1'b1;
          fifo_in_next    = ts_latch;
          pkt_end_next    = pkt_end + 32'(BEAT_BYTES);
        end else begin
          control_next[CTRL_TSMISS] = 1'b1;
        end
        drop_cnt_next = new_sop ? sat_inc32(drop_cnt) : drop_cnt;
        state_next    = ST_ISSUE;
      end
`endif
      ST_ISSUE: begin
        drop_cnt_next = new_sop ? sat_inc32(drop_cnt) : drop_cnt;
        state_next    = ST_WAIT;
      end
      ST_WAIT: begin
        drop_cnt_next = new_sop ? sat_inc32(drop_cnt) : drop_cnt;
        if (wr_ctrl_rdy) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_WAIT;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      st_ready   <= 1'b0;
      fifo_in    <= 32'd0;
      wr_to_fifo <= 1'b0;
      wr_ctrl    <= 1'b0;
      control    <= 32'd0;
      pkt_end    <= 32'd0;
      drop_cnt   <= 32'd0;
    end else begin
      state      <= state_next;
      st_ready   <= 1'b1;
      fifo_in    <= fifo_in_next;
      wr_to_fifo <= wr_to_fifo_next;
      wr_ctrl    <= (state_next == ST_ISSUE);
      control    <= control_next;
      pkt_end    <= pkt_end_next;
      drop_cnt   <= drop_cnt_next;
    end
  end

  capture_ring_ptr #(
    .MAX_PKT_BYTES (MAX_PKT_BYTES),
    .BUF_BASE      (BUF_BASE),
    .BUF_SIZE      (BUF_SIZE)
  ) u_ring_ptr (
    .clk           (clk),
    .reset         (reset),
    .advance       ((state == ST_WAIT) && wr_ctrl_rdy),
    .len           (pkt_end),
    .write_address (write_address)
  );

endmodule

// File: tb/tb_pkt_capture.sv
// Directed table-driven bench for pkt_capture (4 KiB ring so wrap is reachable).
module tb_pkt_capture;

  logic        clk = 1'b0;
  logic        reset, enable, st_valid, st_sop, st_eop, fifo_full, wr_ctrl_rdy;
  logic [31:0] st_data;
  logic [1:0]  st_empty;
  logic        st_ready, wr_to_fifo, wr_ctrl;
  logic [31:0] fifo_in, control, pkt_begin, pkt_end, write_address, drop_cnt;

  always #5 clk = ~clk;

  pkt_capture #(
    .MAX_PKT_BYTES (1520),
    .BUF_BASE      (32'h0000_0000),
    .BUF_SIZE      (32'h0000_1000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .st_data       (st_data),
    .st_valid      (st_valid),
    .st_sop        (st_sop),
    .st_eop        (st_eop),
    .st_empty      (st_empty),
    .st_ready      (st_ready),
    .fifo_in       (fifo_in),
    .wr_to_fifo    (wr_to_fifo),
    .fifo_full     (fifo_full),
    .wr_ctrl       (wr_ctrl),
    .wr_ctrl_rdy   (wr_ctrl_rdy),
    .control       (control),
    .pkt_begin     (pkt_begin),
    .pkt_end       (pkt_end),
    .write_address (write_address),
    .drop_cnt      (drop_cnt)
  );

  typedef struct {
    int          len;
    int          full_beat;
    int          exp_writes;
    logic [31:0] exp_end;
    logic [31:0] exp_ctrl;
    logic [31:0] exp_addr;
    logic [31:0] exp_next;
  } vec_t;

  vec_t        vecs[8];
  vec_t        wrap_vecs[3];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] words[$];
  int          ctrl_pulses = 0;

  // FIFO write and writer-start monitor
  always @(negedge clk) begin
    if (wr_to_fifo) words.push_back(fifo_in);
    if (wr_ctrl) ctrl_pulses++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Beat b of a frame carries {len, b}; stops after max_beats beats.
  task automatic send_frame(input int len, input logic en, input int full_beat, input int max_beats);
    int beats;
    beats = (len + 3) / 4;
    for (int b = 0; b < beats && b < max_beats; b++) begin
      st_valid  = 1'b1;
      st_sop    = (b == 0);
      st_eop    = (b == beats - 1);
      st_empty  = (b == beats - 1) ? 2'(beats * 4 - len) : 2'd0;
      st_data   = {16'(len), 16'(b)};
      enable    = en;
      fifo_full = (b == full_beat);
      step();
    end
    st_valid  = 1'b0;
    st_sop    = 1'b0;
    st_eop    = 1'b0;
    st_empty  = 2'd0;
    fifo_full = 1'b0;
    enable    = 1'b1;
  endtask

  task automatic wait_issue(output logic seen, output logic [31:0] c, output logic [31:0] e,
                            output logic [31:0] a);
    seen = 1'b0; c = 32'd0; e = 32'd0; a = 32'd0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (wr_ctrl) begin
        seen = 1'b1; c = control; e = pkt_end; a = write_address;
      end
    end
    step();
  endtask

  task automatic pulse_rdy();
    wr_ctrl_rdy = 1'b1;
    step();
    wr_ctrl_rdy = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int          base, pbase;
    logic        seen;
    logic [31:0] c, e, a;
    base  = words.size();
    pbase = ctrl_pulses;
    send_frame(v.len, 1'b1, v.full_beat, 100000);
    wait_issue(seen, c, e, a);
    chk({tag, ".issue"}, 32'(seen), 32'd1);
    chk({tag, ".control"}, c, v.exp_ctrl);
    chk({tag, ".pkt_end"}, e, v.exp_end);
    chk({tag, ".addr"}, a, v.exp_addr);
    chk({tag, ".writes"}, 32'(words.size() - base), 32'(v.exp_writes));
    if (words.size() > base) begin
      chk({tag, ".first_word"}, words[base], {16'(v.len), 16'd0});
      chk({tag, ".last_word"}, words[words.size() - 1], {16'(v.len), 16'(v.exp_writes - 1)});
    end
    pulse_rdy();
    chk({tag, ".next_addr"}, write_address, v.exp_next);
    chk({tag, ".pulses"}, 32'(ctrl_pulses - pbase), 32'd1);
  endtask

  initial begin
    int          base, pbase;
    logic        seen;
    logic [31:0] c, e, a;

    vecs[0] = '{64,   -1, 16,  32'd64,   32'h0040_0001, 32'd0,    32'd64};
    vecs[1] = '{61,   -1, 16,  32'd64,   32'h003D_0001, 32'd64,   32'd128};
    vecs[2] = '{2000, -1, 380, 32'd1520, 32'h07D0_0003, 32'd128,  32'd1648};
    vecs[3] = '{4,    -1, 1,   32'd4,    32'h0004_0001, 32'd1648, 32'd1664};
    vecs[4] = '{1520, -1, 380, 32'd1520, 32'h05F0_0001, 32'd1664, 32'd0};
    vecs[5] = '{1521, -1, 380, 32'd1520, 32'h05F1_0003, 32'd0,    32'd1520};
    vecs[6] = '{5,    -1, 2,   32'd8,    32'h0005_0001, 32'd1520, 32'd1536};
    vecs[7] = '{32,    3, 3,   32'd12,   32'h0020_0003, 32'd1536, 32'd1552};
    wrap_vecs[0] = '{1500, -1, 375, 32'd1500, 32'h05DC_0001, 32'd0,    32'd1504};
    wrap_vecs[1] = '{1500, -1, 375, 32'd1500, 32'h05DC_0001, 32'd1504, 32'd0};
    wrap_vecs[2] = '{1500, -1, 375, 32'd1500, 32'h05DC_0001, 32'd0,    32'd1504};

    reset = 1'b0; enable = 1'b1; st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
    st_empty = 2'd0; st_data = 32'd0; fifo_full = 1'b0; wr_ctrl_rdy = 1'b0;
    repeat (3) step();
    chk("rst.st_ready", 32'(st_ready), 32'd0);
    chk("rst.wr_to_fifo", 32'(wr_to_fifo), 32'd0);
    chk("rst.wr_ctrl", 32'(wr_ctrl), 32'd0);
    chk("rst.fifo_in", fifo_in, 32'd0);
    chk("rst.control", control, 32'd0);
    chk("rst.pkt_end", pkt_end, 32'd0);
    chk("rst.write_address", write_address, 32'd0);
    chk("rst.drop_cnt", drop_cnt, 32'd0);
    reset = 1'b1;
    step();
    chk("run.st_ready", 32'(st_ready), 32'd1);
    chk("run.pkt_begin", pkt_begin, 32'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Second frame arrives while the first waits for the writer
    send_frame(64, 1'b1, -1, 100000);
    wait_issue(seen, c, e, a);
    chk("wait.issue", 32'(seen), 32'd1);
    chk("wait.addr", a, 32'd1552);
    base  = words.size();
    pbase = ctrl_pulses;
    send_frame(32, 1'b1, -1, 100000);
    repeat (3) step();
    chk("wait.drop_writes", 32'(words.size() - base), 32'd0);
    chk("wait.drop_cnt", drop_cnt, 32'd1);
    chk("wait.no_pulse", 32'(ctrl_pulses - pbase), 32'd0);
    chk("wait.addr_hold", write_address, 32'd1552);
    pulse_rdy();
    chk("wait.next_addr", write_address, 32'd1616);
    run_vec('{4, -1, 1, 32'd4, 32'h0004_0001, 32'd1616, 32'd1632}, "after_wait");

    // Frame with enable low at SOP is ignored without counting
    base  = words.size();
    pbase = ctrl_pulses;
    send_frame(16, 1'b0, -1, 100000);
    repeat (5) step();
    chk("dis.writes", 32'(words.size() - base), 32'd0);
    chk("dis.pulses", 32'(ctrl_pulses - pbase), 32'd0);
    chk("dis.drop_cnt", drop_cnt, 32'd1);

    // One-cycle reset in the middle of a capture
    send_frame(64, 1'b1, -1, 5);
    reset = 1'b0;
    step();
    chk("mid.st_ready", 32'(st_ready), 32'd0);
    chk("mid.wr_to_fifo", 32'(wr_to_fifo), 32'd0);
    chk("mid.wr_ctrl", 32'(wr_ctrl), 32'd0);
    chk("mid.fifo_in", fifo_in, 32'd0);
    chk("mid.control", control, 32'd0);
    chk("mid.pkt_end", pkt_end, 32'd0);
    chk("mid.write_address", write_address, 32'd0);
    chk("mid.drop_cnt", drop_cnt, 32'd0);
    reset = 1'b1;
    step();
    chk("mid.st_ready_back", 32'(st_ready), 32'd1);
    run_vec(vecs[0], "after_rst");

    // Back-to-back 1500-byte frames from a fresh ring
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    for (int i = 0; i < 3; i++) run_vec(wrap_vecs[i], $sformatf("wrap%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
